// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: function codes, the arbiter
// state encoding and a helper that classifies function codes.
package alu_pkg;

    localparam logic [5:0] FUNCT_ADDU = 6'b001001;
    localparam logic [5:0] FUNCT_SUBU = 6'b001010;
    localparam logic [5:0] FUNCT_OR   = 6'b010010;
    localparam logic [5:0] FUNCT_SRL  = 6'b100010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // True for the function codes the ALU actually implements.
    function automatic logic funct_supported(input logic [5:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_OR, FUNCT_SRL: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU: unsigned add/subtract, bitwise OR and a
// logical right shift. Unknown function codes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] src_data,
    input  logic [31:0] tar_data,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    output logic [31:0] result
);

    // Decode the function code; arithmetic wraps at 32 bits.
    always_comb begin
        result = 32'd0;
        case (funct)
            FUNCT_ADDU: result = src_data + tar_data;
            FUNCT_SUBU: result = src_data - tar_data;
            FUNCT_OR:   result = src_data | tar_data;
            FUNCT_SRL:  result = src_data >> shamt;
            default:    result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. A lone requester always wins; when both
// request, the one that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

    // One-hot grant; on contention favour the port opposite to 'last'.
    always_comb begin
        grant = 2'b00;
        any   = |req;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and
// valid/ready handshakes on both sides. One operation is in flight at a time:
// IDLE accepts, EXEC captures the ALU result, RESP holds it for the owner.
// Optional feature: define ALU_ARB_FUNCT_CHECK_EN to add the rsp_err output,
// which flags unsupported function codes and forces their result to zero.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit ARB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_tar0,
    input  logic [31:0] req_tar1,
    input  logic [4:0]  req_shamt0,
    input  logic [4:0]  req_shamt1,
    input  logic [5:0]  req_funct0,
    input  logic [5:0]  req_funct1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
`ifdef ALU_ARB_FUNCT_CHECK_EN
    output logic        rsp_err,
`endif
    output logic        busy
);

    localparam logic LAST_RESET = ~ARB_FIRST;

    arb_state_t  state;
    arb_state_t  state_next;
    logic        last;
    logic        owner;
    logic [31:0] op_src;
    logic [31:0] op_tar;
    logic [4:0]  op_shamt;
    logic [5:0]  op_funct;
    logic [1:0]  grant;
    logic        grant_any;
    logic        accept;
    logic        sel;
    logic [31:0] alu_result;

    rr_pick2 u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (grant),
        .any   (grant_any)
    );

    alu u_alu (
        .src_data (op_src),
        .tar_data (op_tar),
        .shamt    (op_shamt),
        .funct    (op_funct),
        .result   (alu_result)
    );

    // Request side: only IDLE offers a grant, and never while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !rst) begin
            req_ready = grant;
        end
        accept = grant_any && (|(req_valid & req_ready));
        sel    = req_ready[1];
    end

    // Next-state logic and response-side outputs decoded from the state.
    always_comb begin
        state_next = state;
        rsp_valid  = 2'b00;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = owner ? 2'b10 : 2'b01;
                if (rsp_ready[owner]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning port's operands and remember it for fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= LAST_RESET;
            owner    <= 1'b0;
            op_src   <= 32'd0;
            op_tar   <= 32'd0;
            op_shamt <= 5'd0;
            op_funct <= 6'd0;
        end else if (accept) begin
            last     <= sel;
            owner    <= sel;
            op_src   <= sel ? req_src1   : req_src0;
            op_tar   <= sel ? req_tar1   : req_tar0;
            op_shamt <= sel ? req_shamt1 : req_shamt0;
            op_funct <= sel ? req_funct1 : req_funct0;
        end
    end

`ifdef ALU_ARB_FUNCT_CHECK_EN
    // Capture the result in EXEC, forcing zero and flagging unknown codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= 32'd0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            if (funct_supported(op_funct)) begin
                rsp_data <= alu_result;
                rsp_zero <= (alu_result == 32'd0);
                rsp_err  <= 1'b0;
            end else begin
                rsp_data <= 32'd0;
                rsp_zero <= 1'b1;
                rsp_err  <= 1'b1;
            end
        end
    end
`else
    // Capture the result in EXEC; zero flag derives from the captured value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= 32'd0;
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= alu_result;
            rsp_zero <= (alu_result == 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected
// responses into a queue; a monitor pops and compares on each response
// handshake. Honours ALU_ARB_FUNCT_CHECK_EN when it is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_src0, req_src1, req_tar0, req_tar1;
    logic [4:0]  req_shamt0, req_shamt1;
    logic [5:0]  req_funct0, req_funct1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        busy;
`ifdef ALU_ARB_FUNCT_CHECK_EN
    logic        rsp_err;
    localparam logic ERR_UNSUP = 1'b1;
`else
    localparam logic ERR_UNSUP = 1'b0;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_arbiter #(.ARB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src0   (req_src0),
        .req_src1   (req_src1),
        .req_tar0   (req_tar0),
        .req_tar1   (req_tar1),
        .req_shamt0 (req_shamt0),
        .req_shamt1 (req_shamt1),
        .req_funct0 (req_funct0),
        .req_funct1 (req_funct1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
`ifdef ALU_ARB_FUNCT_CHECK_EN
        .rsp_err    (rsp_err),
`endif
        .busy       (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] src,
                                 input logic [31:0] tar, input logic [4:0] shamt,
                                 input logic [5:0] funct);
        if (port == 0) begin
            req_src0 = src; req_tar0 = tar; req_shamt0 = shamt; req_funct0 = funct;
            req_valid[0] = 1'b1;
        end else begin
            req_src1 = src; req_tar1 = tar; req_shamt1 = shamt; req_funct1 = funct;
            req_valid[1] = 1'b1;
        end
    endtask

    task automatic pushExp(input logic [1:0] vld, input logic [31:0] data,
                           input logic zero, input logic err);
        exp_t e;
        e.vld = vld; e.data = data; e.zero = zero; e.err = err;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the DUT to return to IDLE, then aligns to just after a rising edge.
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
`ifdef ALU_ARB_FUNCT_CHECK_EN
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
`else
                if (e.err) checkOutput("rsp_err_model", 32'd1, 32'd0);
`endif
            end
        end
    end

    initial begin
        int grants;
        int expected_port;
        int n;

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_src0 = 0; req_src1 = 0; req_tar0 = 0; req_tar1 = 0;
        req_shamt0 = 0; req_shamt1 = 0; req_funct0 = 0; req_funct1 = 0;

        // Reset state, with a request pending that must not be readied.
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(negedge clk);
        checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
`ifdef ALU_ARB_FUNCT_CHECK_EN
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
`endif

        // Streaming contention from reset: grants must alternate 0,1,0,1.
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        applyStimulus(0, 32'd5, 32'd5, 5'd0, FUNCT_SUBU);
        applyStimulus(1, 32'h000000F0, 32'h0000000F, 5'd0, FUNCT_OR);
        grants = 0;
        n = 0;
        while (grants < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if ((req_valid & req_ready) != 2'b00) begin
                expected_port = grants % 2;
                checkOutput("stream_grant", {30'd0, req_ready},
                            (expected_port == 0) ? 32'd1 : 32'd2);
                if (req_ready[1]) pushExp(2'b10, 32'h000000FF, 1'b0, 1'b0);
                else              pushExp(2'b01, 32'h00000000, 1'b1, 1'b0);
                grants++;
            end
        end
        checkOutput("stream_grant_count", grants, 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitIdle();

        // Port 0 ADDU wrap-around with exact latency.
        applyStimulus(0, 32'hFFFFFFFF, 32'd2, 5'd0, FUNCT_ADDU);
        @(negedge clk);
        checkOutput("lat_req_ready", {30'd0, req_ready}, 32'd1);
        pushExp(2'b01, 32'h00000001, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("lat_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("lat_exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("lat_resp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        waitIdle();

        // Port 1 SRL held in RESP; rsp_ready[0] from the non-owner is ignored.
        rsp_ready = 2'b00;
        applyStimulus(1, 32'h80000000, 32'd0, 5'd31, FUNCT_SRL);
        @(negedge clk);
        checkOutput("hold_req_ready", {30'd0, req_ready}, 32'd2);
        pushExp(2'b10, 32'h00000001, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("hold_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(0, 32'd1, 32'd1, 5'd0, FUNCT_ADDU);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            checkOutput("hold_rsp_data", rsp_data, 32'h00000001);
            checkOutput("hold_rsp_zero", {31'd0, rsp_zero}, 32'd0);
            checkOutput("hold_req_ready_zero", {30'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            rsp_ready = (i >= 3) ? 2'b01 : 2'b00;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        waitIdle();

        // Unsupported function code yields zero.
        rsp_ready = 2'b11;
        applyStimulus(0, 32'd5, 32'd6, 5'd3, 6'b000000);
        @(negedge clk);
        checkOutput("unsup_req_ready", {30'd0, req_ready}, 32'd1);
        pushExp(2'b01, 32'h00000000, 1'b1, ERR_UNSUP);
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitIdle();

        // Reset during EXEC discards the operation and restores 'last'.
        applyStimulus(0, 32'd3, 32'd4, 5'd0, FUNCT_ADDU);
        @(negedge clk);
        checkOutput("rstx_req_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstx_req_ready_in_reset", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 32'd10, 32'd20, 5'd0, FUNCT_ADDU);
        applyStimulus(1, 32'd1, 32'd2, 5'd0, FUNCT_OR);
        @(negedge clk);
        checkOutput("rstx_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstx_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rstx_last_reverted", {30'd0, req_ready}, 32'd1);
        pushExp(2'b01, 32'd30, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitIdle();

        // Drain: every expected response must have been seen.
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU instance between two requesters (port 0, port 1) with round-robin arbitration and valid/ready handshakes on both the request and response sides. The block sits between the issue logic and the ALU. It latches the granted operands, runs one ALU operation, and holds the result until the originating port accepts it. At most one operation is in flight at a time.

## Interface
- `ARB_FIRST`, default 0: port that wins the first contention after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  2  per-port request valid; bit i belongs to port i.
- `req_ready`  out  2  per-port request accept.
- `req_src0`, `req_src1`  in  32 each  per-port src_data operand.
- `req_tar0`, `req_tar1`  in  32 each  per-port tar_data operand.
- `req_shamt0`, `req_shamt1`  in  5 each  per-port shift amount.
- `req_funct0`, `req_funct1`  in  6 each  per-port function code.
- `rsp_valid`  out  2  per-port result valid.
- `rsp_ready`  in  2  per-port result accept.
- `rsp_data`  out  32  result, shared by both ports; meaningful only where `rsp_valid` is set.
- `rsp_zero`  out  1  1 when `rsp_data` is 0.
- `rsp_err`  out  1  unsupported funct; present only with the macro described under Configuration.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- Supported funct codes:
  - ADDU 6'b001001: src + tar.
  - SUBU 6'b001010: src − tar.
  - OR 6'b010010: src | tar.
  - SRL 6'b100010: src >> shamt.
  - Any other code produces 0.
- All arithmetic is 32-bit modulo; carry and borrow are discarded. SRL is a logical shift by 0–31.
- States:
  - **IDLE**: arbitrate. On a handshake (`req_valid[g] & req_ready[g]`), latch src, tar, shamt, funct and owner=g, then go to EXEC.
  - **EXEC**: the ALU is driven from the operand registers. Capture its output into `rsp_data`, and set `rsp_zero` = (captured value == 0), then go to RESP.
  - **RESP**: assert `rsp_valid[owner]`. On `rsp_ready[owner]`, go to IDLE.
- Arbitration, combinational in IDLE only:
  - Only one port valid: that port is granted.
  - Both ports valid: the port ≠ `last` is granted.
  - `last` updates to the granted port on each accepted request.
  - `last` resets to !ARB_FIRST.
- `req_ready` is 0 in EXEC and RESP. At most one `req_ready` bit is set at any time.
- `rsp_zero` comes from the captured result, not from the ALU's own zero output.
- A requester may drop `req_valid` before it is granted; no state changes as a result.
- `rsp_ready` on the non-owner port is ignored.

## Timing
- Reset values:
  - state = IDLE, `last` = !ARB_FIRST.
  - `req_ready` = 2'b00 in the reset cycle, then combinational.
  - `rsp_valid` = 2'b00, `rsp_data` = 0, `rsp_zero` = 0, `rsp_err` = 0, `busy` = 0.
- Latency: handshake in cycle T, then EXEC in T+1, then `rsp_valid` high from T+2.
- Best-case throughput is one operation per 3 cycles: when `rsp_ready` is already high, RESP lasts 1 cycle and IDLE can accept in T+3.
- While in RESP, `rsp_data`, `rsp_zero` and `rsp_err` stay stable until the handshake.
- `rsp_valid` must not drop before `rsp_ready`.
- Reset asserted in any state: return to IDLE next edge. Any in-flight operation is discarded and no response is issued.
- A request presented in the same cycle as a response handshake waits for IDLE (1 cycle). There is no bypass.

## Configuration
- `ALU_ARB_FUNCT_CHECK_EN`, when defined:
  - EXEC sets `rsp_err` = 1 and forces `rsp_data` = 0 for unsupported funct codes.
  - `rsp_zero` follows the forced 0, i.e. it is 1.
- When undefined:
  - The `rsp_err` port is absent.
  - Unsupported codes return the ALU's default value of 0 with no flag.

## Structure
- Shared package `alu_pkg`:
  - funct localparams `FUNCT_ADDU`, `FUNCT_SUBU`, `FUNCT_OR`, `FUNCT_SRL`.
  - state enum `arb_state_t` {IDLE, EXEC, RESP}.
  - function `funct_supported(funct)`.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last`; outputs are a one-hot grant and an `any` flag.
- The existing ALU is instantiated once and driven only from the operand registers.

## Test plan
- Port 0 only, ADDU 0xFFFFFFFF + 2: `rsp_valid` = 2'b01 at T+2, data 0x00000001, zero 0.
- Both ports valid every cycle from reset with ARB_FIRST=0, streaming, ops SUBU 5−5 (port 0) and OR 0xF0|0x0F (port 1): grants alternate 0,1,0,1. Port 0 gets data 0 with zero=1; port 1 gets 0xFF.
- Port 1, SRL src 0x80000000 shamt 31, `rsp_ready` held low 4 cycles: `rsp_valid[1]` and data 0x00000001 are stable throughout, and `req_ready` stays 0.
- Port 0, funct 6'b000000: data 0, zero 1. With the macro, `rsp_err` = 1. Without the macro, the `rsp_err` port is absent.
- Reset pulsed during EXEC: no `rsp_valid` follows. The next request is accepted 1 cycle after reset deasserts, and `last` has reverted.
- `rsp_ready[0]` asserted while owner = 1: the response is held until `rsp_ready[1]`.
